// File: rtl/npu_pkg.sv
// Shared types and helpers for the systolic MAC array: control state encoding,
// accumulator/index width functions and the final result narrowing.
package npu_pkg;

  localparam int SATW = 64;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic int acc_w(input int dw, input int rows);
    return 2 * dw + $clog2(rows);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamps to the dw-bit signed range when sat is set; otherwise the caller keeps the low dw bits.
  function automatic logic signed [SATW-1:0] sat_resize(input logic signed [SATW-1:0] v,
                                                        input int dw, input bit sat);
    logic signed [SATW-1:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (!sat) return v;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: stationary weight, registered x pass-through and multiply-accumulate.
// en freezes the datapath registers; weight writes are independent of en.
module systolic_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   w_load,
  input  logic [DW-1:0]          w_data,
  input  logic signed [DW-1:0]   x_in,
  input  logic signed [ACCW-1:0] psum_in,
  output logic signed [DW-1:0]   x_out,
  output logic signed [ACCW-1:0] psum_out
);

  logic signed [DW-1:0]   w;
  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(x_in) * (2*DW)'(w);

  always_ff @(posedge clk) begin
    if (rst) begin
      w        <= '0;
      x_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w <= w_data;
      if (en) begin
        x_out    <= x_in;
        psum_out <= psum_in + ACCW'(prod);
      end
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Weight-stationary systolic matrix-vector engine, y[c] = sum_r x[r]*W[r][c], latency ROWS+COLS.
// Whole pipeline stalls while an output is held by backpressure; weight writes only while idle.
module systolic_mac_array
  import npu_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16,
  parameter int SAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wld_valid,
  output logic                   wld_ready,
  input  logic [idx_w(ROWS)-1:0] wld_row,
  input  logic [idx_w(COLS)-1:0] wld_col,
  input  logic [DW-1:0]          wld_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DW-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*DW-1:0]     out_data,
  output logic                   busy
);

  localparam int ACCW = acc_w(DW, ROWS);
  localparam int LAT  = ROWS + COLS;
  localparam int CW   = $clog2(LAT + 1);
  localparam int RW   = idx_w(ROWS);
  localparam int CLW  = idx_w(COLS);

  state_t          state;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            adv, acc, ret;
  logic [LAT-2:0]  vch;

  logic signed [DW-1:0]   xw       [ROWS][COLS];
  logic signed [DW-1:0]   x_east   [ROWS][COLS];
  logic signed [DW-1:0]   x_unused [ROWS];
  logic signed [ACCW-1:0] ps       [ROWS+1][COLS];
  logic signed [ACCW-1:0] col_out  [COLS];
  logic [DW-1:0]          y_sat    [COLS];

  assign adv       = !(out_valid && !out_ready);
  assign wld_ready = (state == ST_IDLE);
  assign in_ready  = adv && !(state == ST_IDLE && wld_valid);
  assign busy      = (state == ST_RUN);
  assign acc       = in_valid && in_ready;
  assign ret       = out_valid && out_ready;
  assign cnt_nxt   = cnt + CW'(acc) - CW'(ret);

  // Row r sees its element r cycles late so partial sums meet the right x on the way down.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign xw[0][0] = in_data[DW-1:0];
    end else begin : g_dly
      logic signed [DW-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= in_data[r*DW +: DW];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign xw[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign ps[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .w_load   (wld_valid && wld_ready && wld_row == RW'(r) && wld_col == CLW'(c)),
        .w_data   (wld_data),
        .x_in     (xw[r][c]),
        .psum_in  (ps[r][c]),
        .x_out    (x_east[r][c]),
        .psum_out (ps[r+1][c])
      );
      if (c > 0) begin : g_link
        assign xw[r][c] = x_east[r][c-1];
      end
    end
    assign x_unused[r] = x_east[r][COLS-1];
  end

  // Column c finishes c cycles after column 0; delay it so the whole vector lines up.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign col_out[c] = ps[ROWS][c];
    end else begin : g_dly
      logic signed [ACCW-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= ps[ROWS][c];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign col_out[c] = sr[D-1];
    end
    assign y_sat[c] = DW'(sat_resize(SATW'(col_out[c]), DW, SAT != 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vch       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      vch[0] <= acc;
      for (int i = 1; i < LAT - 1; i++) vch[i] <= vch[i-1];
      out_valid <= vch[LAT-2];
      for (int c = 0; c < COLS; c++) out_data[c*DW +: DW] <= y_sat[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        ST_IDLE: if (acc) state <= ST_RUN;
        ST_RUN:  if (cnt_nxt == '0) state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: a saturating and a wrapping instance share all inputs.
`timescale 1ns/1ps
module tb_systolic_mac_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wld_valid = 1'b0;
  logic [1:0]  wld_row = '0;
  logic [1:0]  wld_col = '0;
  logic [15:0] wld_data = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        wld_ready, in_ready, out_valid, busy;
  logic [63:0] out_data;
  logic        wld_ready0, in_ready0, out_valid0, busy0;
  logic [63:0] out_data0;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] wm [4][4];

  always #5 clk = ~clk;

  systolic_mac_array #(.ROWS(4), .COLS(4), .DW(16), .SAT(1)) dut (
    .clk(clk), .rst(rst), .wld_valid(wld_valid), .wld_ready(wld_ready), .wld_row(wld_row),
    .wld_col(wld_col), .wld_data(wld_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  systolic_mac_array #(.ROWS(4), .COLS(4), .DW(16), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .wld_valid(wld_valid), .wld_ready(wld_ready0), .wld_row(wld_row),
    .wld_col(wld_col), .wld_data(wld_data), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .busy(busy0)
  );

  task automatic load_weights();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        wld_valid = 1'b1; wld_row = 2'(r); wld_col = 2'(c); wld_data = wm[r][c];
      end
    end
    @(negedge clk);
    wld_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0) $display("FAIL rst_out_data got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL rst_out_valid0 got %b want 0", out_valid0); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int n;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 16'(c + 1);
    load_weights();
    @(negedge clk);
    in_valid = 1'b1; in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL t1_in_ready got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL t1_busy got %b want 1", busy); else pass_cnt++;
    wait_out(n);
    total_cnt++; if (n + 1 != 8) $display("FAIL t1_latency got %0d want 8", n + 1); else pass_cnt++;
    total_cnt++; if (out_data !== {16'd40, 16'd30, 16'd20, 16'd10})
      $display("FAIL t1_data got %h want %h", out_data, {16'd40, 16'd30, 16'd20, 16'd10}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t1_retire busy=%b vld=%b want 0 0", busy, out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] ex;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 16'(16 * r + c + 1);
    load_weights();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h1 << (16 * k);
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL t2_in_ready[%0d] got %b want 1", k, in_ready); else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t2_timeout got %b want 1", out_valid); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) ex[c*16 +: 16] = wm[k][c];
      total_cnt++; if (out_valid !== 1'b1 || out_data !== ex)
        $display("FAIL t2_row[%0d] vld=%b got %h want %h", k, out_valid, out_data, ex); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL t2_extra got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    int n, s;
    logic [63:0] ex [6];
    for (int k = 0; k < 6; k++) begin
      s = k / 4 + 1;
      ex[k] = '0;
      for (int c = 0; c < 4; c++) ex[k][c*16 +: 16] = 16'(s * wm[k % 4][c]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'(k / 4 + 1) << (16 * (k % 4));
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL t3_in_ready[%0d] got %b want 1", k, in_ready); else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t3_timeout got %b want 1", out_valid); else pass_cnt++;
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1 || out_data !== ex[0] || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL t3_hold vld=%b dat=%h rdy=%b busy=%b want 1 %h 0 1", out_valid, out_data, in_ready, busy, ex[0]);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total_cnt++; if (out_valid !== 1'b1 || out_data !== ex[k])
        $display("FAIL t3_drain[%0d] vld=%b got %h want %h", k, out_valid, out_data, ex[k]); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL t3_dup got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_saturate();
    int n;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 16'h7FFF;
    load_weights();
    @(negedge clk);
    in_valid = 1'b1; in_data = {4{16'h7FFF}};
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t4_timeout got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== {4{16'h7FFF}}) $display("FAIL t4_sat_pos got %h want %h", out_data, {4{16'h7FFF}}); else pass_cnt++;
    total_cnt++; if (out_data0 !== {4{16'h0004}}) $display("FAIL t4_wrap_pos got %h want %h", out_data0, {4{16'h0004}}); else pass_cnt++;
    @(negedge clk);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 16'hFFFF;
    load_weights();
    @(negedge clk);
    in_valid = 1'b1; in_data = {16'h0000, 16'h0000, 16'h4000, 16'h4000};
    @(negedge clk);
    in_data = {16'h0000, 16'h0001, 16'h4000, 16'h4000};
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_data !== {4{16'h8000}}) $display("FAIL t4_sat_min got %h want %h", out_data, {4{16'h8000}}); else pass_cnt++;
    total_cnt++; if (out_data0 !== {4{16'h8000}}) $display("FAIL t4_wrap_min got %h want %h", out_data0, {4{16'h8000}}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_data !== {4{16'h8000}}) $display("FAIL t4_sat_neg got %h want %h", out_data, {4{16'h8000}}); else pass_cnt++;
    total_cnt++; if (out_data0 !== {4{16'h7FFF}}) $display("FAIL t4_wrap_neg got %h want %h", out_data0, {4{16'h7FFF}}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_weight_priority();
    int n, seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h1;
    @(negedge clk);
    in_valid = 1'b0;
    wld_valid = 1'b1; wld_row = 2'd0; wld_col = 2'd0; wld_data = 16'd5;
    #1;
    total_cnt++; if (wld_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL t5_blocked wld_ready=%b busy=%b want 0 1", wld_ready, busy); else pass_cnt++;
    seen = 0; n = 0;
    while (!wld_ready && n < 40) begin
      if (out_valid) begin
        seen++;
        total_cnt++; if (out_data !== {4{16'hFFFF}})
          $display("FAIL t5_old_w got %h want %h", out_data, {4{16'hFFFF}}); else pass_cnt++;
      end
      @(negedge clk);
      n++;
    end
    total_cnt++; if (wld_ready !== 1'b1 || busy !== 1'b0 || seen != 1)
      $display("FAIL t5_release wld_ready=%b busy=%b outs=%0d want 1 0 1", wld_ready, busy, seen); else pass_cnt++;
    in_valid = 1'b1; in_data = 64'h1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL t5_w_first got in_ready=%b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    wld_valid = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL t5_in_after got in_ready=%b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0005})
      $display("FAIL t5_new_w vld=%b got %h want %h", out_valid, out_data, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0005});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n, bad;
    @(negedge clk);
    in_valid = 1'b1; in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    @(negedge clk);
    in_data = {16'd8, 16'd7, 16'd6, 16'd5};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL t6_after_rst busy=%b vld=%b want 0 0", busy, out_valid); else pass_cnt++;
    bad = 0;
    repeat (12) begin
      if (out_valid) bad++;
      @(negedge clk);
    end
    total_cnt++; if (bad != 0) $display("FAIL t6_ghost got %0d outputs want 0", bad); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL t6_busy got %b want 0", busy); else pass_cnt++;
    in_valid = 1'b1; in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t6_timeout got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0) $display("FAIL t6_cleared_w got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_data0 !== 64'h0) $display("FAIL t6_cleared_w0 got %h want 0", out_data0); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_saturate();
    test_weight_priority();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
